// File: rtl/reg_preloader.sv
// reg_preloader: stalls the CPU and streams preload beats into the register file, optionally zeroing r1..r7 first.
module reg_preloader #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 8,
  parameter int CLEAR = 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       in_reg_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_last_i,
  input  logic             cpu_we_i,
  input  logic [2:0]       cpu_rd_i,
  input  logic [WIDTH-1:0] cpu_data_i,
  output logic             rf_we_o,
  output logic [2:0]       rf_rd_o,
  output logic [WIDTH-1:0] rf_data_o,
  output logic             cpu_hold_o,
  output logic             done_o,
  output logic             err_o,
  output logic [3:0]       count_o
);
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_LOAD, S_DONE} state_t;
  localparam logic [2:0] LAST = 3'(SIZE - 1);
  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic             we_q, we_d;
  logic [2:0]       rd_q, rd_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [3:0]       count_q, count_d;
  logic             err_q, err_d;
  logic             acc, idle, clr;
  always_comb begin
    acc     = state_q == S_LOAD && in_valid_i;
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = acc && in_reg_i != 3'd0;
    rd_d    = in_reg_i;
    data_d  = in_data_i;
    count_d = count_q;
    err_d   = err_q;
    if (state_q == S_IDLE && start_i) begin
      state_d = CLEAR != 0 ? S_CLEAR : S_LOAD;
      count_d = 4'd0;
      err_d   = 1'b0;
    end
    if (state_q == S_CLEAR) begin
      idx_d   = idx_q == LAST ? 3'd1 : idx_q + 3'd1;
      state_d = idx_q == LAST ? S_LOAD : S_CLEAR;
    end
    if (acc) begin
      count_d = in_reg_i != 3'd0 && count_q != 4'd15 ? count_q + 4'd1 : count_q;
      err_d   = err_q || in_reg_i == 3'd0;
      state_d = in_last_i ? S_DONE : S_LOAD;
    end
    if (state_q == S_DONE) state_d = S_IDLE;
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd1;
      we_q    <= 1'b0;
      rd_q    <= 3'd0;
      data_q  <= '0;
      count_q <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end
  // a pending write is suppressed while reset is asserted so it never reaches the regfile
  always_comb begin
    idle       = state_q == S_IDLE;
    clr        = state_q == S_CLEAR;
    in_ready_o = state_q == S_LOAD;
    cpu_hold_o = !idle;
    done_o     = state_q == S_DONE;
    err_o      = err_q;
    count_o    = count_q;
    rf_we_o    = idle ? cpu_we_i : !reset_i && (clr || we_q);
    rf_rd_o    = idle ? cpu_rd_i : clr ? idx_q : rd_q;
    rf_data_o  = idle ? cpu_data_i : clr ? '0 : data_q;
  end
endmodule

// File: tb/tb_reg_preloader.sv
// tb_reg_preloader: directed vectors against a CLEAR=0 and a CLEAR=1 instance.
module tb_reg_preloader;
  logic clk = 1'b0;
  logic rst, start0, start1, in_valid, in_last, cpu_we;
  logic [2:0] in_reg, cpu_rd;
  logic [7:0] in_data, cpu_data;
  logic rdy0, we0, hold0, done0, err0, rdy1, we1, hold1, done1, err1;
  logic [2:0] rd0, rd1;
  logic [7:0] dat0, dat1;
  logic [3:0] cnt0, cnt1;
  logic [7:0] mdl [8];
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  reg_preloader #(.WIDTH(8), .SIZE(8), .CLEAR(0)) u_d0 (
    .clock_i(clk), .reset_i(rst), .start_i(start0), .in_valid_i(in_valid), .in_ready_o(rdy0),
    .in_reg_i(in_reg), .in_data_i(in_data), .in_last_i(in_last), .cpu_we_i(cpu_we),
    .cpu_rd_i(cpu_rd), .cpu_data_i(cpu_data), .rf_we_o(we0), .rf_rd_o(rd0), .rf_data_o(dat0),
    .cpu_hold_o(hold0), .done_o(done0), .err_o(err0), .count_o(cnt0));
  reg_preloader #(.WIDTH(8), .SIZE(8), .CLEAR(1)) u_d1 (
    .clock_i(clk), .reset_i(rst), .start_i(start1), .in_valid_i(in_valid), .in_ready_o(rdy1),
    .in_reg_i(in_reg), .in_data_i(in_data), .in_last_i(in_last), .cpu_we_i(cpu_we),
    .cpu_rd_i(cpu_rd), .cpu_data_i(cpu_data), .rf_we_o(we1), .rf_rd_o(rd1), .rf_data_o(dat1),
    .cpu_hold_o(hold1), .done_o(done1), .err_o(err1), .count_o(cnt1));
  always @(posedge clk) if (we0) mdl[rd0] <= dat0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [2:0] r, input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_reg   = r;
    in_data  = d;
    in_last  = l;
  endtask
  initial begin
    foreach (mdl[i]) mdl[i] = 8'h00;
    rst = 1'b1; start0 = 0; start1 = 0; in_valid = 0; in_last = 0; cpu_we = 0;
    in_reg = 0; cpu_rd = 0; in_data = 0; cpu_data = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_hold", hold0, 0);
    check("rst_ready", rdy0, 0);
    check("rst_done", done0, 0);
    check("rst_err", err0, 0);
    check("rst_count", cnt0, 0);
    // idle passthrough
    cpu_we = 1; cpu_rd = 3'd4; cpu_data = 8'h33;
    #1;
    check("pass_we", we0, 1);
    check("pass_rd", rd0, 4);
    check("pass_data", dat0, 8'h33);
    cpu_we = 0;
    // clear sequence on the CLEAR=1 instance
    start1 = 1;
    tick();
    start1 = 0;
    for (int i = 1; i <= 7; i++) begin
      #1;
      check("clr_we", we1, 1);
      check("clr_rd", rd1, i);
      check("clr_data", dat1, 0);
      check("clr_hold", hold1, 1);
      check("clr_ready", rdy1, 0);
      tick();
    end
    check("clr_then_ready", rdy1, 1);
    beat(3'd1, 8'h09, 1);
    tick();
    in_valid = 0;
    check("clr_done", done1, 1);
    check("clr_wr_rd", rd1, 1);
    tick();
    check("clr_idle_hold", hold1, 0);
    // three-beat session, CLEAR=0
    start0 = 1;
    tick();
    start0 = 0;
    check("load_ready", rdy0, 1);
    check("load_nowr", we0, 0);
    beat(3'd3, 8'h5A, 0);
    tick();
    beat(3'd5, 8'hFF, 0);
    #1;
    check("w1_we", we0, 1);
    check("w1_rd", rd0, 3);
    check("w1_data", dat0, 8'h5A);
    tick();
    beat(3'd3, 8'h11, 1);
    #1;
    check("w2_rd", rd0, 5);
    check("w2_data", dat0, 8'hFF);
    tick();
    in_valid = 0;
    #1;
    check("w3_we", we0, 1);
    check("w3_rd", rd0, 3);
    check("w3_data", dat0, 8'h11);
    check("w3_done", done0, 1);
    check("w3_ready", rdy0, 0);
    check("w3_count", cnt0, 3);
    tick();
    check("s1_done_gone", done0, 0);
    check("s1_hold", hold0, 0);
    check("rf_r3", mdl[3], 8'h11);
    check("rf_r5", mdl[5], 8'hFF);
    // r0 beat, cpu write during LOAD not forwarded
    start0 = 1;
    tick();
    start0 = 0;
    cpu_we = 1; cpu_rd = 3'd4; cpu_data = 8'h33;
    #1;
    check("load_cpu_blocked", we0, 0);
    beat(3'd0, 8'h77, 0);
    tick();
    beat(3'd2, 8'h01, 1);
    #1;
    check("r0_nowr", we0, 0);
    check("r0_err", err0, 1);
    check("r0_count", cnt0, 0);
    tick();
    in_valid = 0; cpu_we = 0;
    check("r2_rd", rd0, 2);
    check("r2_count", cnt0, 1);
    tick();
    check("err_sticky", err0, 1);
    check("rf_r2", mdl[2], 8'h01);
    check("rf_r0", mdl[0], 8'h00);
    // last beat targeting r0
    start0 = 1;
    tick();
    start0 = 0;
    check("start_clears_err", err0, 0);
    beat(3'd0, 8'h44, 1);
    tick();
    in_valid = 0;
    check("r0last_done", done0, 1);
    check("r0last_we", we0, 0);
    check("r0last_err", err0, 1);
    tick();
    // start held through DONE: one IDLE cycle before the next session
    start0 = 1;
    tick();
    beat(3'd1, 8'h21, 1);
    tick();
    in_valid = 0;
    check("hold_start_done", done0, 1);
    tick();
    check("hold_start_idle", hold0, 0);
    tick();
    start0 = 0;
    check("hold_start_reload", rdy0, 1);
    beat(3'd1, 8'h22, 1);
    tick();
    in_valid = 0;
    tick();
    // reset right after accepting a beat
    start0 = 1;
    tick();
    start0 = 0;
    beat(3'd6, 8'h42, 0);
    tick();
    in_valid = 0;
    rst = 1;
    #1;
    check("rst_mid_nowr", we0, 0);
    tick();
    rst = 0;
    #1;
    check("rst_mid_hold", hold0, 0);
    check("rst_mid_count", cnt0, 0);
    check("rst_mid_ready", rdy0, 0);
    check("rf_r6", mdl[6], 8'h00);
    // 18 beats, count saturates
    start0 = 1;
    tick();
    start0 = 0;
    beat(3'd1, 8'd0, 0);
    for (int i = 0; i < 18; i++) begin
      tick();
      if (i < 17) beat(3'((i + 1) % 7 + 1), 8'(i + 1), i == 16);
      else in_valid = 0;
      #1;
      check("sat_we", we0, 1);
      check("sat_rd", rd0, i % 7 + 1);
      check("sat_data", dat0, i);
      check("sat_count", cnt0, i < 15 ? i + 1 : 15);
    end
    check("sat_done", done0, 1);
    tick();
    check("sat_idle", hold0, 0);
    check("sat_final", cnt0, 15);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_preloader.md
REG_PRELOADER -- requirements
Module: reg_preloader

Interface
REQ-001 Parameter WIDTH, default 8, register data width.
REQ-002 Parameter SIZE, default 8, register count; register index width is 3 bits.
REQ-003 Parameter CLEAR, default 1; 1 zeroes r1..r7 before loading.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 start  input  1  request a preload session; sampled only in IDLE.
REQ-007 in_valid  input  1  preload beat valid.
REQ-008 in_ready  output  1  preloader accepts beat this cycle.
REQ-009 in_reg  input  3  target register index.
REQ-010 in_data  input  WIDTH  value to write.
REQ-011 in_last  input  1  marks final beat of session.
REQ-012 cpu_we / cpu_rd / cpu_data  input  1/3/WIDTH  processor regfile write port.
REQ-013 rf_we / rf_rd / rf_data  output  1/3/WIDTH  regfile write port.
REQ-014 cpu_hold  output  1  processor must stall while high.
REQ-015 done  output  1  one-cycle pulse at session end.
REQ-016 err  output  1  sticky; beat targeting r0 was received.
REQ-017 count  output  4  writes committed this session, saturating at 15.

Function
REQ-018 States: IDLE, CLEAR, LOAD, DONE.
REQ-019 IDLE: cpu_hold=0; rf_we/rf_rd/rf_data combinationally equal cpu_we/cpu_rd/cpu_data; in_ready=0.
REQ-020 IDLE and start=1 at an edge: go to CLEAR if CLEAR=1, else LOAD; count and err clear to 0 on same edge.
REQ-021 cpu_hold=1 in CLEAR, LOAD, DONE; cpu_* inputs ignored; rf_* driven from registered internal write stage.
REQ-022 CLEAR: index counter 1..7; one write per cycle, rf_we=1, rf_rd=index, rf_data=0; after index 7 go to LOAD; CLEAR writes do not increment count.
REQ-023 LOAD: in_ready=1; beat accepted when in_valid and in_ready high at an edge.
REQ-024 Accepted beat with in_reg!=0: write stage loads; during next cycle rf_we=1, rf_rd=in_reg, rf_data=in_data; count increments (saturating at 15).
REQ-025 Accepted beat with in_reg=0: no write (rf_we=0 next cycle), err set, count unchanged.
REQ-026 Throughput one beat per cycle; no back-pressure inside LOAD; in_valid=0 cycles produce rf_we=0.
REQ-027 Accepted beat with in_last=1: LOAD -> DONE; that beat's write occurs in the DONE cycle.
REQ-028 DONE: in_ready=0, done=1 for exactly one cycle, then IDLE unconditionally.
REQ-029 start while not IDLE is ignored; start held high through DONE begins a new session only after one IDLE cycle.
REQ-030 Same-register repeated beats: each writes in order; last value wins.
REQ-031 in_last with in_reg=0: session ends, err set, no write.

Reset
REQ-032 reset=1 at an edge, any state including mid-CLEAR or mid-LOAD: state IDLE, write stage cleared (no pending write issued), count=0, err=0, done=0, index counter=1.
REQ-033 After reset, outputs follow REQ-019 passthrough; reset has priority over start and in_valid.

Verification
REQ-034 CLEAR=1, start pulse -> cycles 1-7 rf_we=1 rf_rd=1..7 rf_data=0, then in_ready=1; cpu_hold=1 throughout.
REQ-035 CLEAR=0, beats (r3,0x5A),(r5,0xFF),(r3,0x11,last) on consecutive cycles -> writes r3=0x5A, r5=0xFF, r3=0x11 on following cycles; done in the r3=0x11 cycle; count=3; regfile readback r3=0x11, r5=0xFF.
REQ-036 Beat (r0,0x77) then (r2,0x01,last) -> no r0 write, err=1 stays set in IDLE, count=1, r2=0x01.
REQ-037 IDLE with cpu_we=1, cpu_rd=4, cpu_data=0x33 -> same cycle rf_we=1, rf_rd=4, rf_data=0x33; cpu_we=1 during LOAD -> not forwarded.
REQ-038 reset asserted cycle after accepting (r6,0x42) -> no r6 write, state IDLE, cpu_hold=0, count=0.
REQ-039 18 non-r0 beats in one session -> count saturates at 15; all 18 writes issued.
